// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
//   Shared constants for the two-stage CIC decimator and for any block that
//   reuses its rounding/saturation stage (e.g. the IIR cascade output scaler).
//
//   CIC_DW       sample width (signed two's complement)
//   CIC_R_LOG2   log2 of the decimation ratio
//   CIC_IW       integrator/comb width: DW plus the CIC bit growth N*log2(R)
//   CIC_SHIFT    right shift that removes the R^2 gain
//   CIC_RND      half-LSB constant added before the shift
//   CIC_SAT_MAX  largest representable output sample
//   CIC_SAT_MIN  smallest representable output sample
// -----------------------------------------------------------------------------
package cic_pkg;

    localparam int CIC_DW      = 12;
    localparam int CIC_R_LOG2  = 4;
    localparam int CIC_IW      = CIC_DW + 2 * CIC_R_LOG2;
    localparam int CIC_SHIFT   = 2 * CIC_R_LOG2;
    localparam int CIC_RND     = 1 << (CIC_SHIFT - 1);
    localparam int CIC_SAT_MAX = (1 << (CIC_DW - 1)) - 1;
    localparam int CIC_SAT_MIN = -(1 << (CIC_DW - 1));

endpackage

// File: rtl/cic_round_sat.sv
// -----------------------------------------------------------------------------
// cic_round_sat
//   Combinational IW -> DW scaler: round half toward +inf, arithmetic shift
//   right by SHIFT, then clamp to the signed DW-bit range.
//
//   Ports:
//     din   input  IW  signed wide value
//     dout  output DW  signed rounded and saturated value
// -----------------------------------------------------------------------------
module cic_round_sat
    import cic_pkg::*;
#(
    parameter int IW    = CIC_IW,
    parameter int DW    = CIC_DW,
    parameter int SHIFT = CIC_SHIFT
) (
    input  logic signed [IW-1:0] din,
    output logic signed [DW-1:0] dout
);

    // One guard bit keeps the rounding add from wrapping at the positive rail.
    localparam logic signed [IW:0] RND_C = (IW + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IW:0] MAX_C = (IW + 1)'((1 << (DW - 1)) - 1);
    localparam logic signed [IW:0] MIN_C = (IW + 1)'(-(1 << (DW - 1)));

    function automatic logic signed [IW:0] round_shift(input logic signed [IW-1:0] x);
        logic signed [IW:0] t;
        t = {x[IW-1], x} + RND_C;
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [IW:0] x);
        logic signed [IW:0] t;
        if (x > MAX_C) begin
            t = MAX_C;
        end else if (x < MIN_C) begin
            t = MIN_C;
        end else begin
            t = x;
        end
        return t[DW-1:0];
    endfunction

    always_comb begin
        dout = saturate(round_shift(din));
    end

endmodule

// File: rtl/cic2_decim.sv
// -----------------------------------------------------------------------------
// cic2_decim
//   Two-stage CIC decimator (N = 2, R = 2^R_LOG2) with unity DC gain. Feeds
//   each second-order IIR section at the decimated rate.
//
//   Ports:
//     clk        input  1       system clock
//     rst_n      input  1       asynchronous active-low reset
//     in_valid   input  1       in_data accepted this cycle
//     in_data    input  DW      signed input sample
//     out_valid  output 1       one-cycle strobe for a new out_data
//     out_data   output DW      signed decimated sample, held between strobes
//     phase      output R_LOG2  samples accepted in the current window
//
//   Timing: the R-th sample of a window is accepted in cycle T; the comb runs
//   in T+1 on the dump strobe; out_valid/out_data appear in T+2.
// -----------------------------------------------------------------------------
module cic2_decim
    import cic_pkg::*;
#(
    parameter int DW     = CIC_DW,
    parameter int R_LOG2 = CIC_R_LOG2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DW-1:0]     in_data,
    output logic                     out_valid,
    output logic signed [DW-1:0]     out_data,
    output logic        [R_LOG2-1:0] phase
);

    localparam int IW    = DW + 2 * R_LOG2;
    localparam int SHIFT = 2 * R_LOG2;

    logic        [R_LOG2-1:0] phase_p0;
    logic signed [IW-1:0]     i1_p0, i2_p0;
    logic signed [IW-1:0]     i1_next, i2_next;
    logic                     dump;
    logic                     vld_p0;
    logic signed [IW-1:0]     i2_d, c1_d;
    logic signed [IW-1:0]     c1, c2;
    logic signed [DW-1:0]     scaled;
    logic signed [DW-1:0]     data_p1;
    logic                     vld_p1;

    // ---- stage 0: integrators at the input rate ----------------------------
    always_comb begin
        i1_next = i1_p0 + {{(IW - DW){in_data[DW-1]}}, in_data};
        i2_next = i2_p0 + i1_next;
        dump    = in_valid && (phase_p0 == '1);
    end

    // Integrators intentionally wrap modulo 2^IW; the comb differences undo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_p0    <= '0;
            i2_p0    <= '0;
            phase_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= dump;
            if (in_valid) begin
                i1_p0    <= i1_next;
                i2_p0    <= i2_next;
                phase_p0 <= phase_p0 + 1'b1;
            end
        end
    end

    // ---- stage 1: combs at the decimated rate, on the dump strobe -----------
    // i2_p0 may already hold the next window's first sample when a new sample
    // lands in T+1, but it is only read through the registered snapshot below
    // on the strobe cycle, where it still holds the dump-cycle value.
    always_comb begin
        c1 = i2_p0 - i2_d;
        c2 = c1 - c1_d;
    end

    cic_round_sat #(
        .IW    (IW),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .din  (c2),
        .dout (scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2_d    <= '0;
            c1_d    <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                i2_d    <= i2_p0;
                c1_d    <= c1;
                data_p1 <= scaled;
            end
        end
    end

    // ---- stage 2: outputs --------------------------------------------------
    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign phase     = phase_p0;

endmodule
